// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: stalls, flushes and mult/div busy tracking for the mips32 core.
// Optional HAZARD_STALL_CNT_EN adds a saturating stall_cnt output (cycles with pc_we=0).
module hazard_ctrl #(
  parameter int MD_LAT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        id_md_op,
  input  logic        id_hilo_rd,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        ex_br_taken,
  input  logic        imem_ready,
  input  logic        mem_req,
  input  logic        dmem_ready,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        if_id_flush,
  output logic        id_ex_we,
  output logic        id_ex_flush,
  output logic        ex_mem_we,
  output logic        md_start,
  output logic        md_busy,
  output logic        md_done,
`ifdef HAZARD_STALL_CNT_EN
  output logic [31:0] stall_cnt,
`endif
  output logic [0:0]  dbg_md_state
);

  localparam int CW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MD_LAT - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} md_state_t;

  md_state_t       state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            frz, br, lu, mdh, ifw;

  // Memory handshakes: a stage's data is valid only in a cycle where its ready
  // (imem_ready / dmem_ready) is high; an active mem_req without dmem_ready freezes the pipe.
  assign frz = mem_req & ~dmem_ready;
  assign br  = ex_br_taken;
  assign lu  = ex_mem_read & (ex_rt != 5'd0) &
               ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  assign mdh = md_busy & (id_md_op | id_hilo_rd);
  assign ifw = ~imem_ready;

  assign md_busy      = ~rst & (state == BUSY);
  assign md_done      = md_busy & (cnt == '0);
  assign md_start     = ~rst & id_md_op & ~frz & ~br & ~lu & ~mdh &
                        ((state == IDLE) | md_done);
  assign dbg_md_state = state;

  always_comb begin
    pc_we       = 1'b1;
    if_id_we    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_we    = 1'b1;
    id_ex_flush = 1'b0;
    ex_mem_we   = 1'b1;
    if (rst) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_we    = 1'b0;
      id_ex_flush = 1'b1;
      ex_mem_we   = 1'b0;
    end else if (frz) begin
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      id_ex_we  = 1'b0;
      ex_mem_we = 1'b0;
    end else if (br) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (lu | mdh) begin
      // ID holds its instruction and a bubble goes down into EX
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (ifw) begin
      pc_we       = 1'b0;
      if_id_flush = 1'b1;
    end
  end

  // Mult/div tracker keeps counting through freezes; the unit itself never stalls.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (md_start) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  stall_cnt <= '0;
    else if (!pc_we && (stall_cnt != '1))     stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed hazard scenarios plus randomized traffic against a
// cycle-level reference model (remaining-cycles count for mult/div). Honors HAZARD_STALL_CNT_EN.
module tb_hazard_ctrl;
  localparam int MD_LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, id_md_op, id_hilo_rd, ex_mem_read, ex_br_taken;
  logic        imem_ready, mem_req, dmem_ready;
  logic        pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we;
  logic        md_start, md_busy, md_done;
  logic [0:0]  dbg_md_state;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [8:0]  exp_q[$];
  int          md_left;
  logic [31:0] stall_model;
  logic        exp_start, exp_pc_we;

  hazard_ctrl #(.MD_LAT(MD_LAT)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_md_op(id_md_op), .id_hilo_rd(id_hilo_rd),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_br_taken(ex_br_taken),
    .imem_ready(imem_ready), .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .id_ex_we(id_ex_we), .id_ex_flush(id_ex_flush), .ex_mem_we(ex_mem_we),
    .md_start(md_start), .md_busy(md_busy), .md_done(md_done),
`ifdef HAZARD_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .dbg_md_state(dbg_md_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [8:0] got_vec();
    return {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we,
            md_start, md_busy, md_done};
  endfunction

  // Reference model: decide which pipeline action wins this cycle and what it means.
  task automatic model_expect();
    logic frz, lu, mdh, busy, done;
    logic [5:0] we_fl;
    busy = (md_left > 0);
    done = (md_left == 1);
    frz  = mem_req && !dmem_ready;
    lu   = ex_mem_read && ex_rt != 0 &&
           (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    mdh  = busy && (id_md_op || id_hilo_rd);
    // order: pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we
    if (frz)              we_fl = 6'b000000;
    else if (ex_br_taken) we_fl = 6'b111111;
    else if (lu || mdh)   we_fl = 6'b000111;
    else if (!imem_ready) we_fl = 6'b011101;
    else                  we_fl = 6'b110101;
    exp_start = id_md_op && !frz && !ex_br_taken && !lu && !mdh && md_left <= 1;
    exp_pc_we = we_fl[5];
    exp_q.push_back({we_fl, exp_start, busy, done});
  endtask

  // driver: inputs are set at the negedge before calling; checks then advances one clock
  task automatic cycle(input string tag);
    logic [8:0] e;
    #1;
    model_expect();
    e = exp_q.pop_front();
    check(tag, {23'd0, got_vec()}, {23'd0, e});
`ifdef HAZARD_STALL_CNT_EN
    check({tag, "_scnt"}, stall_cnt, stall_model);
`endif
    @(posedge clk);
    if (md_left > 0) md_left--;
    if (exp_start) md_left = MD_LAT;
    if (!exp_pc_we && stall_model != 32'hFFFF_FFFF) stall_model++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    #1;
    check("rst_ctl", {23'd0, got_vec()}, 32'b001010000);
    md_left     = 0;
    stall_model = 32'd0;
`ifdef HAZARD_STALL_CNT_EN
    check("rst_scnt", stall_cnt, 32'd0);
`endif
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle_in();
    id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b1;
    id_md_op = 1'b0; id_hilo_rd = 1'b0;
    ex_mem_read = 1'b0; ex_rt = 5'd0; ex_br_taken = 1'b0;
    imem_ready = 1'b1; mem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  function automatic logic [4:0] pick_reg();
    logic [4:0] r;
    case ($urandom_range(0, 3))
      0:       r = 5'd0;
      1:       r = 5'd8;
      2:       r = 5'd9;
      default: r = 5'($urandom_range(0, 31));
    endcase
    return r;
  endfunction

  initial begin
    rst = 1'b1;
    md_left = 0;
    stall_model = 32'd0;
    idle_in();
    @(negedge clk);
    do_reset(2);

    // load-use on rs
    idle_in(); ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    #1;
    check("t1_pc_we", pc_we, 0);
    check("t1_if_id_we", if_id_we, 0);
    check("t1_id_ex_flush", id_ex_flush, 1);
    cycle("t1");
    idle_in(); cycle("t1_after");

    // no stall on $zero load or unused rt
    idle_in(); ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    #1; check("t2_zero_pc_we", pc_we, 1);
    cycle("t2_zero");
    idle_in(); ex_mem_read = 1'b1; ex_rt = 5'd8; id_rt = 5'd8; id_uses_rt = 1'b0; id_rs = 5'd3;
    #1; check("t2_rt_pc_we", pc_we, 1);
    cycle("t2_rt");

    // branch beats load-use
    idle_in(); ex_br_taken = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    #1;
    check("t3_pc_we", pc_we, 1);
    check("t3_if_id_flush", if_id_flush, 1);
    check("t3_id_ex_flush", id_ex_flush, 1);
    cycle("t3");

    // data-memory freeze holds the branch for 3 cycles
    for (int i = 0; i < 3; i++) begin
      idle_in(); ex_br_taken = 1'b1; mem_req = 1'b1; dmem_ready = 1'b0;
      #1;
      check("t4_frz_we", {pc_we, if_id_we, id_ex_we, ex_mem_we}, 4'b0000);
      check("t4_frz_flush", {if_id_flush, id_ex_flush}, 2'b00);
      cycle("t4_frz");
    end
    dmem_ready = 1'b1;
    #1; check("t4_release_flush", {if_id_flush, id_ex_flush}, 2'b11);
    cycle("t4_release");

    // mult then mflo held for the busy window
    idle_in(); id_md_op = 1'b1;
    #1; check("t5_start", md_start, 1);
    cycle("t5_issue");
    for (int i = 0; i < MD_LAT; i++) begin
      idle_in(); id_hilo_rd = 1'b1;
      #1;
      check("t5_busy", md_busy, 1);
      check("t5_hold", pc_we, 0);
      check("t5_done", md_done, (i == MD_LAT - 1) ? 1 : 0);
      cycle("t5_wait");
    end
    #1;
    check("t5_mflo_go", pc_we, 1);
    check("t5_idle", md_busy, 0);
    cycle("t5_mflo");

    // reset in the second busy cycle kills the operation without md_done
    idle_in(); id_md_op = 1'b1; cycle("t5r_issue");
    idle_in(); cycle("t5r_busy1");
    do_reset(1);
    for (int i = 0; i < MD_LAT + 1; i++) begin
      idle_in(); id_hilo_rd = 1'b1;
      #1; check("t5r_no_md", {md_busy, md_done}, 2'b00);
      cycle("t5r_after");
    end

`ifdef HAZARD_STALL_CNT_EN
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      idle_in(); imem_ready = 1'b0; cycle("t6_ifw");
    end
    idle_in(); ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; cycle("t6_lu");
    idle_in();
    #1; check("t6_cnt", stall_cnt, 32'd6);
    do_reset(1);
`endif

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset($urandom_range(1, 2));
      end else begin
        id_rs       = pick_reg();
        id_rt       = pick_reg();
        ex_rt       = pick_reg();
        id_uses_rt  = ($urandom_range(0, 1) == 1);
        id_md_op    = ($urandom_range(0, 5) == 0);
        id_hilo_rd  = ($urandom_range(0, 4) == 0);
        ex_mem_read = ($urandom_range(0, 2) == 0);
        ex_br_taken = ($urandom_range(0, 6) == 0);
        imem_ready  = ($urandom_range(0, 4) != 0);
        mem_req     = ($urandom_range(0, 2) == 0);
        dmem_ready  = ($urandom_range(0, 1) == 1);
        cycle("rand");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
